// File: rtl/mux16_stream_arb.sv
// mux16_stream_arb
//   Two-input packet arbiter for 16-bit valid/ready streams. The grant is
//   held for the whole packet, from the first beat until the beat with last=1.
//   A round-robin pointer alternates priority between channels when both
//   request at a packet boundary. Beats pass through a one-entry output
//   register that can load and be consumed in the same cycle.
//
// Handshake: a beat moves on a channel in every cycle where valid and ready
//   are both 1 at the rising clk edge. A producer holds valid, data and last
//   stable until that edge. Ready may depend combinationally on valid. On the
//   output side, out_data and out_last stay stable while out_valid=1 and
//   out_ready=0.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   a_data     channel A beat data (16)
//   a_valid    channel A beat present
//   a_last     channel A beat is the final beat of its packet
//   a_ready    channel A beat accepted this cycle
//   b_data     channel B beat data (16)
//   b_valid    channel B beat present
//   b_last     channel B beat is the final beat of its packet
//   b_ready    channel B beat accepted this cycle
//   out_data   registered selected beat (16)
//   out_valid  out_data holds an unconsumed beat
//   out_last   registered last flag of out_data
//   out_ready  downstream accepts the beat when out_valid=1
//   sel        current grant, 0 = A and 1 = B; selects the data mux
//   fsm_state  debug view of the FSM: 0 = IDLE, 1 = LOCK_A, 2 = LOCK_B
//   prio       debug view of the round-robin pointer, 0 = A preferred
module mux16_stream_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a_data,
  input  logic        a_valid,
  input  logic        a_last,
  output logic        a_ready,
  input  logic [15:0] b_data,
  input  logic        b_valid,
  input  logic        b_last,
  output logic        b_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        sel,
  output logic [1:0]  fsm_state,
  output logic        prio
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  state_t      state;
  logic        prio_q;
  logic        sel_q;     // last grant, reused in IDLE when nobody requests

  logic        grant_raw;
  logic        grant;
  logic        load_ok;
  logic        a_xfer;
  logic        b_xfer;
  logic        xfer;
  logic [15:0] xfer_data;
  logic        xfer_last;

  // Grant selection. The locked states pin the grant so the other channel
  // cannot interleave beats into an open packet.
  always_comb begin
    grant_raw = sel_q;
    case (state)
      LOCK_A: grant_raw = 1'b0;
      LOCK_B: grant_raw = 1'b1;
      default: begin
        if (a_valid && !b_valid)      grant_raw = 1'b0;
        else if (!a_valid && b_valid) grant_raw = 1'b1;
        else if (a_valid && b_valid)  grant_raw = prio_q;
        else                          grant_raw = sel_q;
      end
    endcase
  end

  // The reset term keeps sel and both readies low for the whole time rst_n
  // is asserted, even while the inputs are still toggling.
  assign grant   = rst_n & grant_raw;
  assign load_ok = rst_n & (~out_valid | out_ready);

  assign a_ready = load_ok & ~grant;
  assign b_ready = load_ok &  grant;

  assign a_xfer  = a_valid & a_ready;
  assign b_xfer  = b_valid & b_ready;
  assign xfer    = a_xfer | b_xfer;

  // Only the granted channel feeds the output register. The load is also
  // gated by that channel's valid, so data with valid=0 is never captured.
  assign xfer_data = grant ? b_data : a_data;
  assign xfer_last = grant ? b_last : a_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio_q    <= 1'b0;
      sel_q     <= 1'b0;
      out_data  <= 16'h0000;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      sel_q <= grant;
      if (xfer) begin
        // A load wins over a consume, so the register stays full with the
        // new beat when both happen in the same cycle.
        out_data  <= xfer_data;
        out_last  <= xfer_last;
        out_valid <= 1'b1;
        if (xfer_last) begin
          state  <= IDLE;
          prio_q <= ~grant;
        end else begin
          state  <= grant ? LOCK_B : LOCK_A;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign sel       = grant;
  assign fsm_state = state;
  assign prio      = prio_q;

endmodule
